// File: rtl/max_pool_seq_if.sv
// ============================================================================
// Module : max_pool_seq_if
// Brief  : Control/address bundle between the max-pool sequencer, the layer
//          controller and the feature/result SRAMs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface max_pool_seq_if #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16,
   parameter int LANES  = 32
) ();
   logic              start;
   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [CNT_W-1:0]  num_win;
   logic [4:0]        win_len;
   logic [LANES-1:0]  lane_mask;
   logic              hold;
   logic              busy;
   logic              done;
   logic              err;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [LANES-1:0]  max_en;
   logic              max_first;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;

   modport master (
      output start, src_base, dst_base, num_win, win_len, lane_mask, hold,
      input  busy, done, err, rd_en, rd_addr, max_en, max_first, wr_en, wr_addr
   );

   modport slave (
      input  start, src_base, dst_base, num_win, win_len, lane_mask, hold,
      output busy, done, err, rd_en, rd_addr, max_en, max_first, wr_en, wr_addr
   );
endinterface

`default_nettype wire

// File: rtl/max_pool_seq.sv
// ============================================================================
// Module : max_pool_seq
// Brief  : Window-by-window sequencer for the 32-lane max-pooling array:
//          issues feature reads, lane enables and result writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max_pool_seq #(
   parameter int ADDR_W   = 16,
   parameter int CNT_W    = 16,
   parameter int LANES    = 32,
   parameter int POOL_MAX = 16
) (
   input  wire logic     clk,
   input  wire logic     rst,
   max_pool_seq_if.slave bus
);

   localparam logic [4:0] c_pool_max = 5'(POOL_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W-1:0] r_lin;
   logic [ADDR_W-1:0] r_wr_idx;
   logic [CNT_W-1:0]  r_num;
   logic [CNT_W-1:0]  r_win;
   logic [4:0]        r_len;
   logic [4:0]        r_elem;
   logic [LANES-1:0]  r_mask;

   // Stage 1 = enable stage, stage 2 = write stage
   logic              r_en1;
   logic              r_first1;
   logic              r_last1;
   logic              r_fin1;
   logic              r_last2;
   logic              r_fin2;
   logic              r_err;

   logic              w_bad;
   logic              w_accept;
   logic              w_reject;
   logic              w_issue;
   logic              w_busy;
   logic              w_elem_last;
   logic              w_win_last;

   assign w_bad       = (bus.win_len == 5'd0) || (bus.win_len > c_pool_max) ||
                        (bus.num_win == '0);
   assign w_elem_last = (r_elem == r_len - 5'd1);
   assign w_win_last  = (r_win == r_num - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_reject = 1'b0;
      w_issue  = 1'b0;
      w_busy   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept = !w_bad;
               w_reject = w_bad;
               if (!w_bad) begin
                  w_next = S_READ;
               end
            end
         end
         S_READ: begin
            w_busy  = 1'b1;
            w_issue = !bus.hold;
            if (w_issue && w_elem_last && w_win_last) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (r_fin2) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_lin    <= '0;
         r_wr_idx <= '0;
         r_num    <= '0;
         r_win    <= '0;
         r_len    <= '0;
         r_elem   <= '0;
         r_mask   <= '0;
         r_en1    <= 1'b0;
         r_first1 <= 1'b0;
         r_last1  <= 1'b0;
         r_fin1   <= 1'b0;
         r_last2  <= 1'b0;
         r_fin2   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_reject;
         if (w_accept) begin
            r_src    <= bus.src_base;
            r_dst    <= bus.dst_base;
            r_num    <= bus.num_win;
            r_len    <= bus.win_len;
            r_mask   <= bus.lane_mask;
            r_lin    <= '0;
            r_win    <= '0;
            r_elem   <= '0;
            r_wr_idx <= '0;
         end else begin
            if (w_issue) begin
               r_lin <= r_lin + ADDR_W'(1);
               if (w_elem_last) begin
                  r_elem <= '0;
                  r_win  <= r_win + CNT_W'(1);
               end else begin
                  r_elem <= r_elem + 5'd1;
               end
            end
            if (r_last2) begin
               r_wr_idx <= r_wr_idx + ADDR_W'(1);
            end
         end
         r_en1    <= w_issue;
         r_first1 <= w_issue && (r_elem == 5'd0);
         r_last1  <= w_issue && w_elem_last;
         r_fin1   <= w_issue && w_elem_last && w_win_last;
         r_last2  <= r_last1;
         r_fin2   <= r_fin1;
      end
   end

   assign bus.busy      = w_busy;
   assign bus.err       = r_err;
   assign bus.done      = r_err | r_fin2;
   assign bus.rd_en     = w_issue;
   assign bus.rd_addr   = w_issue ? (r_src + r_lin) : '0;
   assign bus.max_en    = r_en1 ? r_mask : '0;
   assign bus.max_first = r_first1;
   assign bus.wr_en     = r_last2;
   assign bus.wr_addr   = r_last2 ? (r_dst + r_wr_idx) : '0;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_seq.sv
// ============================================================================
// Module : tb_max_pool_seq
// Brief  : Self-checking bench for max_pool_seq against a timeline model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_pool_seq;

   localparam int MAXC = 1024;

   logic clk;
   logic rst;

   max_pool_seq_if #(.ADDR_W(16), .CNT_W(16), .LANES(32)) bus ();

   max_pool_seq #(
      .ADDR_W(16), .CNT_W(16), .LANES(32), .POOL_MAX(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Expected outputs per cycle, cycle 0 being the start cycle
   bit        e_busy [MAXC];
   bit        e_done [MAXC];
   bit        e_err  [MAXC];
   bit        e_rd   [MAXC];
   bit        e_mf   [MAXC];
   bit        e_wr   [MAXC];
   bit [15:0] e_rda  [MAXC];
   bit [15:0] e_wra  [MAXC];
   bit [31:0] e_men  [MAXC];
   bit        h      [MAXC];

   int cur    = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t cyc=%0d got=%0h exp=%0h", name, $time, cur, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy",      bus.busy,      e_busy[cur]);
         chk("done",      bus.done,      e_done[cur]);
         chk("err",       bus.err,       e_err[cur]);
         chk("rd_en",     bus.rd_en,     e_rd[cur]);
         chk("max_en",    bus.max_en,    e_men[cur]);
         chk("max_first", bus.max_first, e_mf[cur]);
         chk("wr_en",     bus.wr_en,     e_wr[cur]);
         if (e_rd[cur]) chk("rd_addr", bus.rd_addr, e_rda[cur]);
         if (e_wr[cur]) chk("wr_addr", bus.wr_addr, e_wra[cur]);
      end
   end

   // Reads fall on every non-held cycle from 1 on; enable follows by 1, write by 2.
   task automatic build_model(input logic [15:0] src, input logic [15:0] dst,
                              input logic [15:0] nw, input logic [4:0] wl,
                              input logic [31:0] mask,
                              output int len, output int fin, output bit valid);
      int total;
      int k;
      int c;
      for (int i = 0; i < MAXC; i++) begin
         e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_rd[i] = 0; e_mf[i] = 0;
         e_wr[i] = 0; e_rda[i] = 0; e_wra[i] = 0; e_men[i] = 0;
      end
      valid = !(wl == 0 || wl > 16 || nw == 0);
      if (!valid) begin
         e_err[1]  = 1;
         e_done[1] = 1;
         fin = 1;
         len = 4;
         return;
      end
      total = int'(nw) * int'(wl);
      k = 0;
      c = 1;
      while (k < total) begin
         if (!h[c]) begin
            e_rd[c]    = 1;
            e_rda[c]   = src + 16'(k);
            e_men[c+1] = mask;
            e_mf[c+1]  = (k % int'(wl) == 0);
            if (k % int'(wl) == int'(wl) - 1) begin
               e_wr[c+2]  = 1;
               e_wra[c+2] = dst + 16'(k / int'(wl));
            end
            k++;
         end
         c++;
      end
      fin = c + 1;
      e_done[fin] = 1;
      for (int i = 1; i <= fin; i++) e_busy[i] = 1;
      len = fin + 3;
   endtask

   task automatic rand_hold(input int pct);
      for (int i = 0; i < MAXC; i++) h[i] = (i < 600) && ($urandom_range(0, 99) < pct);
   endtask

   task automatic run_op(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] nw, input logic [4:0] wl,
                         input logic [31:0] mask, input bit noisy, input int stop_at);
      int  len;
      int  fin;
      bit  valid;
      build_model(src, dst, nw, wl, mask, len, fin, valid);
      if (stop_at >= 0) len = stop_at;
      for (int rel = 0; rel < len; rel++) begin
         @(posedge clk);
         #1;
         if (rel == 0) begin
            bus.start     = 1'b1;
            bus.src_base  = src;
            bus.dst_base  = dst;
            bus.num_win   = nw;
            bus.win_len   = wl;
            bus.lane_mask = mask;
         end else begin
            bus.start = noisy && valid && rel <= fin && ($urandom_range(0, 5) == 0);
            if (noisy) begin
               bus.src_base  = 16'($urandom);
               bus.dst_base  = 16'($urandom);
               bus.num_win   = 16'($urandom);
               bus.win_len   = 5'($urandom);
               bus.lane_mask = $urandom;
            end
         end
         bus.hold = h[rel];
         cur      = rel;
         chk_on   = 1'b1;
      end
      @(posedge clk);
      #1;
      chk_on    = 1'b0;
      bus.start = 1'b0;
      bus.hold  = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      bus.busy,      0);
      chk({tag, "_done"},      bus.done,      0);
      chk({tag, "_err"},       bus.err,       0);
      chk({tag, "_rd_en"},     bus.rd_en,     0);
      chk({tag, "_rd_addr"},   bus.rd_addr,   0);
      chk({tag, "_max_en"},    bus.max_en,    0);
      chk({tag, "_max_first"}, bus.max_first, 0);
      chk({tag, "_wr_en"},     bus.wr_en,     0);
      chk({tag, "_wr_addr"},   bus.wr_addr,   0);
   endtask

   initial begin
      logic [15:0] nw;
      logic [4:0]  wl;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.src_base  = '0;
      bus.dst_base  = '0;
      bus.num_win   = '0;
      bus.win_len   = '0;
      bus.lane_mask = '0;
      bus.hold      = 1'b0;
      #12;
      chk_all_zero("reset");
      @(posedge clk);
      #2 rst = 1'b0;

      // Single window
      rand_hold(0);
      run_op(16'h0100, 16'h0200, 16'd1, 5'd4, 32'hFFFF_FFFF, 1'b0, -1);
      chk("pin1_rd1",   e_rda[1], 16'h0100);
      chk("pin1_rd4",   e_rda[4], 16'h0103);
      chk("pin1_first", {e_mf[2], e_mf[3]}, 2'b10);
      chk("pin1_men5",  e_men[5], 32'hFFFF_FFFF);
      chk("pin1_wr6",   {e_wr[6], e_done[6], e_busy[6], e_busy[7]}, 4'b1110);

      // Three windows
      run_op(16'h0000, 16'h0040, 16'd3, 5'd2, 32'hFFFF_FFFF, 1'b0, -1);
      chk("pin2_first", {e_mf[2], e_mf[3], e_mf[4], e_mf[5], e_mf[6]}, 5'b10101);
      chk("pin2_wr",    {e_wr[4], e_wr[6], e_wr[8], e_done[8]}, 4'b1111);
      chk("pin2_wra8",  e_wra[8], 16'h0042);

      // Stall on cycle 2
      rand_hold(0);
      h[2] = 1'b1;
      run_op(16'h0100, 16'h0200, 16'd1, 5'd4, 32'hFFFF_FFFF, 1'b0, -1);
      chk("pin3_men3",  e_men[3], 32'h0);
      chk("pin3_rd3",   e_rda[3], 16'h0101);
      chk("pin3_done7", {e_wr[7], e_done[7]}, 2'b11);

      // Bad configurations
      rand_hold(0);
      run_op(16'h0000, 16'h0000, 16'd1, 5'd0,  32'hFFFF_FFFF, 1'b0, -1);
      chk("pin4_err", {e_err[1], e_done[1], e_busy[1]}, 3'b110);
      run_op(16'h0000, 16'h0000, 16'd1, 5'd17, 32'hFFFF_FFFF, 1'b0, -1);
      run_op(16'h0000, 16'h0000, 16'd0, 5'd4,  32'hFFFF_FFFF, 1'b0, -1);

      // Address wrap and partial lane mask
      run_op(16'hFFFE, 16'hFFFF, 16'd2, 5'd4, 32'h0000_000F, 1'b0, -1);
      chk("pin5_wrap", {e_rda[2], e_rda[3]}, {16'hFFFF, 16'h0000});
      chk("pin5_wra",  e_wra[10], 16'h0000);

      // win_len == 1: write every cycle
      run_op(16'h1234, 16'h0300, 16'd5, 5'd1, 32'hA5A5_5A5A, 1'b0, -1);

      // Asynchronous reset during READ at cycle 3
      run_op(16'h0100, 16'h0200, 16'd1, 5'd4, 32'hFFFF_FFFF, 1'b0, 3);
      #1 rst = 1'b1;
      #1 chk_all_zero("midrst");
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("postrst_idle", {bus.busy, bus.rd_en, bus.wr_en, bus.done}, 4'b0000);
      end
      run_op(16'h0100, 16'h0200, 16'd1, 5'd4, 32'hFFFF_FFFF, 1'b0, -1);

      // Random operations with stalls, stray starts and changing inputs
      for (int t = 0; t < 25; t++) begin
         rand_hold($urandom_range(0, 40));
         nw = 16'($urandom_range(1, 6));
         wl = 5'($urandom_range(1, 16));
         case ($urandom_range(0, 9))
            0: wl = 5'd0;
            1: wl = 5'($urandom_range(17, 31));
            2: nw = 16'd0;
            default: ;
         endcase
         run_op(16'($urandom), 16'($urandom), nw, wl, $urandom, 1'b1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
